// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer
//   Initiator for the BabySoC 4-entry register file. It accepts one ALU
//   command per valid/ready handshake, reads both source registers through
//   the combinational read ports, computes the result and writes it back
//   through the single write port. It also reports the result, its flags
//   and a running count of completed write-backs.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_op                  00 ADD, 01 SUB, 10 AND, 11 LOADI
//   cmd_rd/rs1/rs2/imm      destination, sources, immediate
//   ReadReg1/2, ReadData1/2 register file read ports (data is combinational)
//   WriteReg/WriteData      register file write port
//   RegWrite                write enable, committed by the register file on posedge clk
//   rsp_valid               one-cycle pulse in the cycle the result is written
//   rsp_data/zero/carry     result and flags, held until the next EXEC
//   op_count                completed write-backs, wraps modulo 2^CNT_W
module rf_access_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] ReadReg1,
    output logic [ADDR_W-1:0] ReadReg2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_LOADI} op_e;

    state_e              state;
    op_e                 opQ;
    logic [ADDR_W-1:0]   rdQ;
    logic [DATA_W-1:0]   immQ;

    logic                accept;
    logic [DATA_W:0]     sumExt;
    logic [DATA_W:0]     diffExt;
    logic [DATA_W-1:0]   aluRes;
    logic                aluCarry;

    // Write enable and response are gated by rst_n so that a reset landing
    // on the WRITE cycle discards the command instead of committing it.
    assign RegWrite  = (state == WRITE) & rst_n;
    assign rsp_valid = (state == WRITE) & rst_n;
    assign cmd_ready = rst_n & ((state == IDLE) | (state == WRITE));
    assign accept    = cmd_valid & cmd_ready;
    assign rsp_data  = WriteData;

    // Extending both operands by one bit makes the top bit of the difference
    // the unsigned borrow (set exactly when ReadData1 < ReadData2).
    always_comb begin
        sumExt   = {1'b0, ReadData1} + {1'b0, ReadData2};
        diffExt  = {1'b0, ReadData1} - {1'b0, ReadData2};
        aluRes   = '0;
        aluCarry = 1'b0;
        case (opQ)
            OP_ADD: begin
                aluRes   = sumExt[DATA_W-1:0];
                aluCarry = sumExt[DATA_W];
            end
            OP_SUB: begin
                aluRes   = diffExt[DATA_W-1:0];
                aluCarry = diffExt[DATA_W];
            end
            OP_AND: begin
                aluRes   = ReadData1 & ReadData2;
                aluCarry = 1'b0;
            end
            default: begin
                aluRes   = immQ;
                aluCarry = 1'b0;
            end
        endcase
    end

    // The read-port registers double as the latched source indices: they
    // load on accept and therefore hold the sources throughout EXEC and
    // keep their last value afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            opQ       <= OP_ADD;
            rdQ       <= '0;
            immQ      <= '0;
            ReadReg1  <= '0;
            ReadReg2  <= '0;
            WriteReg  <= '0;
            WriteData <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opQ      <= op_e'(cmd_op);
                        rdQ      <= cmd_rd;
                        immQ     <= cmd_imm;
                        ReadReg1 <= cmd_rs1;
                        ReadReg2 <= cmd_rs2;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    WriteReg  <= rdQ;
                    WriteData <= aluRes;
                    rsp_carry <= aluCarry;
                    rsp_zero  <= (aluRes == '0);
                    state     <= WRITE;
                end
                WRITE: begin
                    op_count <= op_count + 1'b1;
                    if (accept) begin
                        opQ      <= op_e'(cmd_op);
                        rdQ      <= cmd_rd;
                        immQ     <= cmd_imm;
                        ReadReg1 <= cmd_rs1;
                        ReadReg2 <= cmd_rs2;
                        state    <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed testbench for rf_access_sequencer with a small 4x4 register file
// model attached to the read/write ports.
module tb_rf_access_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [3:0] cmd_imm;
    logic [1:0] ReadReg1;
    logic [1:0] ReadReg2;
    logic [3:0] ReadData1;
    logic [3:0] ReadData2;
    logic [1:0] WriteReg;
    logic [3:0] WriteData;
    logic       RegWrite;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_carry;
    logic [7:0] op_count;

    int passCount  = 0;
    int checkCount = 0;

    logic [3:0] rf [4];

    always #5 clk = ~clk;

    always @(posedge clk) if (RegWrite) rf[WriteReg] <= WriteData;
    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];

    rf_access_sequencer #(.DATA_W(4), .ADDR_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_carry(rsp_carry), .op_count(op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command, waits for the accept edge, then checks the EXEC
    // and WRITE cycles. Returns during the WRITE cycle so the caller can issue
    // the next command back-to-back.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [3:0] imm, input logic [3:0] expRes,
                           input logic expCarry, input string name);
        int n = 0;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        checkCount++;
        if (!cmd_ready) $display("FAIL %s accept_timeout cmd_ready=%0d expected 1", name, cmd_ready);
        else passCount++;
        step();
        cmd_valid = 1'b0;
        // EXEC cycle
        checkCount++;
        if (rsp_valid !== 1'b0 || RegWrite !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL %s exec_ctrl rsp_valid=%0d RegWrite=%0d cmd_ready=%0d expected 0 0 0",
                     name, rsp_valid, RegWrite, cmd_ready);
        else passCount++;
        checkCount++;
        if (ReadReg1 !== rs1 || ReadReg2 !== rs2)
            $display("FAIL %s exec_readreg got %0d,%0d expected %0d,%0d", name, ReadReg1, ReadReg2, rs1, rs2);
        else passCount++;
        step();
        // WRITE cycle
        checkCount++;
        if (rsp_valid !== 1'b1 || RegWrite !== 1'b1)
            $display("FAIL %s write_ctrl rsp_valid=%0d RegWrite=%0d expected 1 1", name, rsp_valid, RegWrite);
        else passCount++;
        checkCount++;
        if (WriteReg !== rd || WriteData !== expRes || rsp_data !== expRes)
            $display("FAIL %s write_data WriteReg=%0d WriteData=%0d rsp_data=%0d expected %0d %0d %0d",
                     name, WriteReg, WriteData, rsp_data, rd, expRes, expRes);
        else passCount++;
        checkCount++;
        if (rsp_zero !== (expRes == 4'd0) || rsp_carry !== expCarry)
            $display("FAIL %s flags zero=%0d carry=%0d expected %0d %0d",
                     name, rsp_zero, rsp_carry, (expRes == 4'd0), expCarry);
        else passCount++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        step();
        step();
        checkCount++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_ready_held cmd_ready=%0d expected 0", cmd_ready);
        else passCount++;
        checkCount++;
        if (RegWrite !== 1'b0 || op_count !== 8'd0 || WriteData !== 4'd0 || ReadReg1 !== 2'd0)
            $display("FAIL reset_state RegWrite=%0d op_count=%0d WriteData=%0d ReadReg1=%0d expected 0 0 0 0",
                     RegWrite, op_count, WriteData, ReadReg1);
        else passCount++;
        rst_n = 1'b1;
        #1;
        checkCount++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready cmd_ready=%0d expected 1", cmd_ready);
        else passCount++;
        step();
        checkCount++;
        if (RegWrite !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'd0)
            $display("FAIL idle_state RegWrite=%0d rsp_valid=%0d cmd_ready=%0d op_count=%0d expected 0 0 1 0",
                     RegWrite, rsp_valid, cmd_ready, op_count);
        else passCount++;
    endtask

    task automatic test_loadi_init();
        for (int i = 0; i < 4; i++) rf[i] = 4'hA;
        run_cmd(2'b11, 2'd0, 2'd1, 2'd2, 4'd9,  4'd9,  1'b0, "loadi_r0");
        run_cmd(2'b11, 2'd1, 2'd0, 2'd3, 4'd7,  4'd7,  1'b0, "loadi_r1");
        run_cmd(2'b11, 2'd2, 2'd3, 2'd0, 4'd0,  4'd0,  1'b0, "loadi_r2");
        run_cmd(2'b11, 2'd3, 2'd2, 2'd1, 4'd15, 4'd15, 1'b0, "loadi_r3");
        step();
        checkCount++;
        if (op_count !== 8'd4) $display("FAIL loadi_count op_count=%0d expected 4", op_count);
        else passCount++;
        checkCount++;
        if (rf[0] !== 4'd9 || rf[1] !== 4'd7 || rf[2] !== 4'd0 || rf[3] !== 4'd15)
            $display("FAIL loadi_regfile got %0d %0d %0d %0d expected 9 7 0 15", rf[0], rf[1], rf[2], rf[3]);
        else passCount++;
    endtask

    task automatic test_add_carry();
        run_cmd(2'b00, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 1'b1, "add_r0_r1");
        step();
        checkCount++;
        if (rsp_valid !== 1'b0 || RegWrite !== 1'b0)
            $display("FAIL add_pulse_end rsp_valid=%0d RegWrite=%0d expected 0 0", rsp_valid, RegWrite);
        else passCount++;
        checkCount++;
        if (rsp_data !== 4'd0 || rsp_zero !== 1'b1 || rsp_carry !== 1'b1)
            $display("FAIL add_hold rsp_data=%0d zero=%0d carry=%0d expected 0 1 1", rsp_data, rsp_zero, rsp_carry);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        run_cmd(2'b01, 2'd3, 2'd1, 2'd0, 4'd0, 4'd14, 1'b1, "sub_r1_r0");
        run_cmd(2'b10, 2'd0, 2'd3, 2'd1, 4'd0, 4'd6,  1'b0, "and_r3_r1");
        step();
        checkCount++;
        if (rf[0] !== 4'd6 || rf[3] !== 4'd14)
            $display("FAIL b2b_regfile R0=%0d R3=%0d expected 6 14", rf[0], rf[3]);
        else passCount++;
    endtask

    task automatic test_reset_in_write();
        // R0=6, R3=14: 6+14 = 20 -> 4 with carry
        run_cmd(2'b00, 2'd1, 2'd0, 2'd3, 4'd0, 4'd4, 1'b1, "add_before_reset");
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (RegWrite !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL rst_write_gate RegWrite=%0d rsp_valid=%0d cmd_ready=%0d expected 0 0 0",
                     RegWrite, rsp_valid, cmd_ready);
        else passCount++;
        step();
        checkCount++;
        if (rf[1] !== 4'd7) $display("FAIL rst_no_commit R1=%0d expected 7", rf[1]);
        else passCount++;
        checkCount++;
        if (op_count !== 8'd0 || WriteData !== 4'd0 || rsp_carry !== 1'b0 || WriteReg !== 2'd0)
            $display("FAIL rst_clear op_count=%0d WriteData=%0d carry=%0d WriteReg=%0d expected 0 0 0 0",
                     op_count, WriteData, rsp_carry, WriteReg);
        else passCount++;
        rst_n = 1'b1;
        #1;
        checkCount++;
        if (cmd_ready !== 1'b1) $display("FAIL rst_idle_ready cmd_ready=%0d expected 1", cmd_ready);
        else passCount++;
        step();
        checkCount++;
        if (RegWrite !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL rst_idle_quiet RegWrite=%0d rsp_valid=%0d expected 0 0", RegWrite, rsp_valid);
        else passCount++;
    endtask

    task automatic test_count_wrap();
        logic [3:0] v;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                for (int g = 0; g < 3; g++) begin
                    step();
                    checkCount++;
                    if (RegWrite !== 1'b0 || rsp_valid !== 1'b0)
                        $display("FAIL gap_quiet cycle=%0d RegWrite=%0d rsp_valid=%0d expected 0 0",
                                 g, RegWrite, rsp_valid);
                    else passCount++;
                end
            end
            v = 4'(i);
            run_cmd(2'b11, 2'(i), 2'd0, 2'd0, v, v, 1'b0, "loadi_wrap");
            if (i == 255) begin
                checkCount++;
                if (op_count !== 8'd255) $display("FAIL wrap_pre op_count=%0d expected 255", op_count);
                else passCount++;
            end
        end
        step();
        checkCount++;
        if (op_count !== 8'd0) $display("FAIL wrap_zero op_count=%0d expected 0", op_count);
        else passCount++;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 4'd0;
        test_reset();
        test_loadi_init();
        test_add_carry();
        test_back_to_back();
        test_reset_in_write();
        test_count_wrap();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
